// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data memory access controller.
//   - controller state encoding
//   - default wait limit before a memory access is forced to complete
//   - address / data / register-index widths
//   - MEM/WB register layout
package mem_access_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } macState_e;

  localparam int TIMEOUT_DEFAULT = 255;
  localparam int ADDR_W          = 32;
  localparam int DATA_W          = 32;
  localparam int REG_IDX_W       = 5;
  localparam int CNT_MIN_W       = 8;

  // MEM/WB register contents; an all-zero value is a bubble.
  typedef struct packed {
    logic                 regWrite;
    logic                 memtoReg;
    logic [DATA_W-1:0]    memRdata;
    logic [DATA_W-1:0]    aluData;
    logic [REG_IDX_W-1:0] regWaddr;
  } memWb_t;

  // Wait counter width: wide enough to reach TIMEOUT-1, never below 8 bits.
  function automatic int cntWidth(input int timeout);
    int w;
    w = $clog2(timeout);
    return (w > CNT_MIN_W) ? w : CNT_MIN_W;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter for an outstanding data memory access.
// Ports:
//   clk_i   - clock
//   start_i - asynchronous active-low reset
//   clr     - restart the count at zero (access being issued)
//   en      - count one more cycle spent waiting without acknowledge
//   tc      - count has reached TIMEOUT-1 (last cycle allowed to wait)
module mem_wait_timer #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic clk_i,
  input  logic start_i,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data memory access controller.
// Issues one memory request per load/store, stalls the pipeline until the
// memory acknowledges (or a wait limit expires) and produces the MEM/WB
// register. Misaligned accesses and timeouts raise a sticky error flag.
// Ports:
//   clk_i, start_i                  - clock, asynchronous active-low reset
//   RegWrite_i..RegWaddr_i          - EX/MEM register contents
//   mem_ack_i, mem_rdata_i          - memory completion strobe and read data
//   mem_req_o..mem_wdata_o          - memory request, held until completion
//   stall_o                         - freeze EX/MEM and upstream this cycle
//   RegWrite_o..RegWaddr_o          - MEM/WB register
//   err_o                           - sticky misalignment / timeout flag
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 start_i,
  input  logic                 RegWrite_i,
  input  logic                 MemtoReg_i,
  input  logic                 MemRead_i,
  input  logic                 MemWrite_i,
  input  logic [ADDR_W-1:0]    ALUdata_i,
  input  logic [DATA_W-1:0]    MemWdata_i,
  input  logic [REG_IDX_W-1:0] RegWaddr_i,
  input  logic                 mem_ack_i,
  input  logic [DATA_W-1:0]    mem_rdata_i,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic [DATA_W-1:0]    mem_wdata_o,
  output logic                 stall_o,
  output logic                 RegWrite_o,
  output logic                 MemtoReg_o,
  output logic [DATA_W-1:0]    MemRdata_o,
  output logic [DATA_W-1:0]    ALUdata_o,
  output logic [REG_IDX_W-1:0] RegWaddr_o,
  output logic                 err_o
);

  localparam int CNT_W = cntWidth(TIMEOUT);

  macState_e state, stateNext;
  logic      access, aligned, issue, done, timeout;
  logic      stall, timerClr, timerEn, timerTc;
  memWb_t    memWb;

  // EX/MEM copy captured when the access is issued
  logic                 regWrite_p0;
  logic                 memtoReg_p0;
  logic [REG_IDX_W-1:0] regWaddr_p0;

  assign access  = MemRead_i | MemWrite_i;
  assign aligned = (ALUdata_i[1:0] == 2'b00);
  assign issue   = (state == IDLE) & access & aligned;
  // Acknowledge wins over a timeout landing in the same cycle.
  assign timeout = timerTc & ~mem_ack_i;
  assign done    = (state == BUSY) & (mem_ack_i | timeout);

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) uTimer (
    .clk_i   (clk_i),
    .start_i (start_i),
    .clr     (timerClr),
    .en      (timerEn),
    .tc      (timerTc)
  );

  always_comb begin
    stateNext = state;
    stall     = 1'b0;
    timerClr  = 1'b0;
    timerEn   = 1'b0;
    unique case (state)
      IDLE: begin
        if (access && aligned) begin
          stateNext = BUSY;
          stall     = 1'b1;
          timerClr  = 1'b1;
        end
      end
      BUSY: begin
        if (mem_ack_i || timeout) begin
          stateNext = IDLE;
        end else begin
          stall   = 1'b1;
          timerEn = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // While reset is held the pipeline must not be frozen, even though an
  // aligned access may still be presented on the EX/MEM inputs.
  assign stall_o = stall & start_i;

  // ---- EX/MEM capture (no reset: only read after an issue) ----
  always_ff @(posedge clk_i) begin
    if (issue) begin
      regWrite_p0 <= RegWrite_i;
      memtoReg_p0 <= MemtoReg_i;
      regWaddr_p0 <= RegWaddr_i;
    end
  end

  // ---- memory request and MEM/WB register ----
  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      state       <= IDLE;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      memWb       <= '0;
      err_o       <= 1'b0;
    end else begin
      state <= stateNext;
      if (issue) begin
        mem_req_o   <= 1'b1;
        mem_we_o    <= MemWrite_i;
        mem_addr_o  <= ALUdata_i;
        mem_wdata_o <= MemWdata_i;
        memWb       <= '0;
      end else if (state == IDLE) begin
        // Non-access or misaligned access: single-cycle pass-through; a
        // misaligned access must not write back.
        memWb.regWrite <= RegWrite_i & ~access;
        memWb.memtoReg <= MemtoReg_i;
        memWb.memRdata <= '0;
        memWb.aluData  <= ALUdata_i;
        memWb.regWaddr <= RegWaddr_i;
        if (access) begin
          err_o <= 1'b1;
        end
      end else if (done) begin
        mem_req_o      <= 1'b0;
        memWb.regWrite <= regWrite_p0;
        memWb.memtoReg <= memtoReg_p0;
        memWb.memRdata <= (mem_ack_i && !mem_we_o) ? mem_rdata_i : '0;
        memWb.aluData  <= mem_addr_o;
        memWb.regWaddr <= regWaddr_p0;
        if (!mem_ack_i) begin
          err_o <= 1'b1;
        end
      end else begin
        memWb <= '0;
      end
    end
  end

  assign RegWrite_o = memWb.regWrite;
  assign MemtoReg_o = memWb.memtoReg;
  assign MemRdata_o = memWb.memRdata;
  assign ALUdata_o  = memWb.aluData;
  assign RegWaddr_o = memWb.regWaddr;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios followed by
// randomized instruction streams, each checked against a per-instruction
// reference model (expected stall count, MEM/WB result, sticky error).
`timescale 1ns/1ps
module tb_mem_access_ctrl;

  localparam int TO = 4;

  logic        clk_i = 1'b0;
  logic        start_i = 1'b0;
  logic        RegWrite_i = 1'b0, MemtoReg_i = 1'b0, MemRead_i = 1'b0, MemWrite_i = 1'b0;
  logic [31:0] ALUdata_i = '0, MemWdata_i = '0, mem_rdata_i = '0;
  logic [4:0]  RegWaddr_i = '0;
  logic        mem_ack_i = 1'b0;
  logic        mem_req_o, mem_we_o, stall_o, RegWrite_o, MemtoReg_o, err_o;
  logic [31:0] mem_addr_o, mem_wdata_o, MemRdata_o, ALUdata_o;
  logic [4:0]  RegWaddr_o;

  int numChecks = 0;
  int numFails  = 0;
  bit modelErr  = 1'b0;
  bit strayAck  = 1'b0;

  always #5 clk_i = ~clk_i;

  mem_access_ctrl #(.TIMEOUT(TO)) dut (
    .clk_i       (clk_i),
    .start_i     (start_i),
    .RegWrite_i  (RegWrite_i),
    .MemtoReg_i  (MemtoReg_i),
    .MemRead_i   (MemRead_i),
    .MemWrite_i  (MemWrite_i),
    .ALUdata_i   (ALUdata_i),
    .MemWdata_i  (MemWdata_i),
    .RegWaddr_i  (RegWaddr_i),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .stall_o     (stall_o),
    .RegWrite_o  (RegWrite_o),
    .MemtoReg_o  (MemtoReg_o),
    .MemRdata_o  (MemRdata_o),
    .ALUdata_o   (ALUdata_o),
    .RegWaddr_o  (RegWaddr_o),
    .err_o       (err_o)
  );

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    numChecks++;
    if (obs !== exp) begin
      numFails++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic setInputs(input bit rw, input bit mtr, input bit rd, input bit wr,
                           input logic [31:0] alu, input logic [31:0] wdata,
                           input logic [4:0] waddr);
    RegWrite_i = rw;  MemtoReg_i = mtr; MemRead_i = rd; MemWrite_i = wr;
    ALUdata_i  = alu; MemWdata_i = wdata; RegWaddr_i = waddr;
  endtask

  // Hold reset low, check everything is cleared, release at posedge+1.
  task automatic doReset();
    setInputs(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    mem_ack_i = 1'b0;
    start_i   = 1'b0;
    #3;
    checkVal("rst_stall", stall_o, 0);
    checkVal("rst_req", mem_req_o, 0);
    checkVal("rst_err", err_o, 0);
    checkVal("rst_regwrite", RegWrite_o, 0);
    checkVal("rst_aludata", ALUdata_o, 0);
    checkVal("rst_memrdata", MemRdata_o, 0);
    modelErr = 1'b0;
    @(posedge clk_i); #1;
    start_i = 1'b1;
  endtask

  // One instruction through MEM. ackCycle = BUSY cycle in which memory
  // acknowledges (0 = never). Called and returns at posedge+1.
  task automatic runInstr(input bit rw, input bit mtr, input bit rd, input bit wr,
                          input logic [31:0] alu, input logic [31:0] wdata,
                          input logic [4:0] waddr, input int ackCycle,
                          input logic [31:0] rdata);
    bit          access, aligned, issue, acked;
    int          expStalls, stalls, busy;
    logic [31:0] expRdata;
    access    = rd | wr;
    aligned   = (alu[1:0] == 2'b00);
    issue     = access && aligned;
    acked     = issue && ackCycle != 0 && ackCycle <= TO;
    expStalls = !issue ? 0 : (acked ? ackCycle : TO);
    expRdata  = (acked && !wr) ? rdata : 32'h0;
    if ((issue && !acked) || (access && !aligned)) modelErr = 1'b1;

    setInputs(rw, mtr, rd, wr, alu, wdata, waddr);
    mem_rdata_i = rdata;
    stalls = 0;
    busy   = 0;
    forever begin
      if (busy == 0) mem_ack_i = strayAck ? 1'($urandom_range(0, 1)) : 1'b0;
      else           mem_ack_i = (busy == ackCycle);
      #1;
      if (!stall_o) break;
      if (busy > 0) begin
        checkVal("busy_req", mem_req_o, 1);
        checkVal("busy_addr", mem_addr_o, alu);
        checkVal("busy_we", mem_we_o, wr);
        checkVal("busy_wdata", mem_wdata_o, wdata);
      end
      stalls++;
      @(posedge clk_i); #1;
      checkVal("bubble_regwrite", RegWrite_o, 0);
      checkVal("bubble_memtoreg", MemtoReg_o, 0);
      checkVal("bubble_memrdata", MemRdata_o, 0);
      busy++;
      if (stalls > TO + 2) begin
        checkVal("stall_bound", stalls, expStalls);
        mem_ack_i = 1'b0;
        return;
      end
    end
    checkVal("stall_count", stalls, expStalls);
    checkVal("req_before_done", mem_req_o, (busy > 0));
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0;
    checkVal("wb_regwrite", RegWrite_o, (access && !aligned) ? 1'b0 : rw);
    checkVal("wb_memtoreg", MemtoReg_o, mtr);
    checkVal("wb_aludata", ALUdata_o, alu);
    checkVal("wb_regwaddr", RegWaddr_o, waddr);
    checkVal("wb_memrdata", MemRdata_o, expRdata);
    checkVal("err", err_o, modelErr);
    checkVal("req_after_done", mem_req_o, 0);
    if (issue) begin
      checkVal("done_we", mem_we_o, wr);
      checkVal("done_wdata", mem_wdata_o, wdata);
    end
  endtask

  initial begin
    bit          rd, wr;
    logic [31:0] alu;
    int          kind;

    doReset();

    // Plain ALU op passes through with latency 1, no request.
    runInstr(1, 0, 0, 0, 32'h0000_0010, 32'h0, 5'd5, 0, 32'h0);
    // Load acked in third BUSY cycle.
    runInstr(1, 1, 1, 0, 32'h0000_0100, 32'h0, 5'd3, 3, 32'hDEAD_BEEF);
    // Store with immediate ack.
    runInstr(0, 0, 0, 1, 32'h0000_0200, 32'h1234_5678, 5'd0, 1, 32'h5555_AAAA);
    // Ack arriving in the last allowed cycle completes normally.
    runInstr(1, 1, 1, 0, 32'h0000_0300, 32'h0, 5'd9, TO, 32'hCAFE_F00D);
    // Misaligned load: no request, no write-back, sticky error.
    runInstr(1, 1, 1, 0, 32'h0000_0103, 32'h0, 5'd6, 1, 32'h1);
    runInstr(1, 0, 0, 0, 32'h0000_0020, 32'h0, 5'd2, 0, 32'h0);
    // Load never acked: forced completion.
    runInstr(1, 1, 1, 0, 32'h0000_0400, 32'h0, 5'd8, 0, 32'h0000_0BAD);

    // Reset in the second BUSY cycle, then a stray ack must be ignored.
    doReset();
    setInputs(1, 1, 1, 0, 32'h0000_0500, 32'h0, 5'd4);
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    checkVal("pre_rst_req", mem_req_o, 1);
    checkVal("pre_rst_stall", stall_o, 1);
    #2;
    start_i = 1'b0;
    #1;
    checkVal("async_rst_req", mem_req_o, 0);
    checkVal("async_rst_stall", stall_o, 0);
    checkVal("async_rst_addr", mem_addr_o, 0);
    checkVal("async_rst_err", err_o, 0);
    setInputs(1, 0, 0, 0, 32'h0000_0044, 32'h0, 5'd7);
    mem_ack_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b1;
    #1;
    checkVal("stray_stall", stall_o, 0);
    @(posedge clk_i); #1;
    checkVal("stray_req", mem_req_o, 0);
    checkVal("stray_aludata", ALUdata_o, 32'h44);
    checkVal("stray_regwrite", RegWrite_o, 1);
    checkVal("stray_err", err_o, 0);
    mem_ack_i = 1'b0;
    modelErr  = 1'b0;

    // Randomized instruction streams with occasional resets.
    strayAck = 1'b1;
    for (int n = 0; n < 240; n++) begin
      if (n % 40 == 39) doReset();
      kind = $urandom_range(0, 3);
      rd   = (kind == 1) || (kind == 3);
      wr   = (kind == 2) || (kind == 3);
      alu  = $urandom;
      if ($urandom_range(0, 3) != 0) alu[1:0] = 2'b00;
      runInstr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rd, wr, alu,
               $urandom, 5'($urandom_range(0, 31)), $urandom_range(0, TO + 1), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
